// File: rtl/core_pkg.sv
// Shared RV32I core definitions: datapath width, reset/NOP constants and the IF/ID payload.
// The decode stage consumes if_id_t directly.
package core_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic            valid;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } if_id_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter register with its next-PC selection: reset, redirect, stall, increment.
// Redirect targets are forced to word alignment.
module pc_reg
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC_VAL = core_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  // Redirect outranks stall so a taken branch is never lost behind a hazard.
  always_comb begin
    pc_d = pc_q + XLEN'(4);
    if (redirect_valid) begin
      pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (stall) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC_VAL;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: drives imem from the PC and captures the IF/ID register.
// Define FETCH_PERF_CNT_EN to add fetch/bubble performance counters.
module fetch_stage
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC_VAL  = core_pkg::RESET_PC,
  parameter logic [31:0]     NOP_INSTR_VAL = core_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_bubble_cnt
`endif
);

  logic [XLEN-1:0] pc;
  if_id_t          if_id_q;
  if_id_t          if_id_d;

  pc_reg #(
    .RESET_PC_VAL(RESET_PC_VAL)
  ) u_pc_reg (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .pc            (pc)
  );

  // A flush keeps id_pc/id_pc_plus4 so only valid and instr change on a bubble.
  always_comb begin
    if_id_d = if_id_q;
    if (redirect_valid) begin
      if_id_d.valid = 1'b0;
      if_id_d.instr = NOP_INSTR_VAL;
    end else if (!stall) begin
      if_id_d.valid    = 1'b1;
      if_id_d.instr    = imem_rdata;
      if_id_d.pc       = pc;
      if_id_d.pc_plus4 = pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_q.valid    <= 1'b0;
      if_id_q.instr    <= NOP_INSTR_VAL;
      if_id_q.pc       <= '0;
      if_id_q.pc_plus4 <= '0;
    end else begin
      if_id_q <= if_id_d;
    end
  end

  assign imem_addr   = pc;
  assign id_valid    = if_id_q.valid;
  assign id_instr    = if_id_q.instr;
  assign id_pc       = if_id_q.pc;
  assign id_pc_plus4 = if_id_q.pc_plus4;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] bubble_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else if (redirect_valid) begin
      bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end else if (!stall) begin
      fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt  = fetch_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the driver queues expected post-edge state, the monitor checks it.
// Counter checks are compiled in when FETCH_PERF_CNT_EN is defined.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_bubble_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] fcnt;
    logic [31:0] bcnt;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  // Instruction memory: each word is tagged with its own low address half.
  assign imem_rdata = {16'hC0DE, imem_addr[15:0]};

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_valid      (id_valid),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .id_pc_plus4   (id_pc_plus4)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, req);
    end
  endtask

  // Monitor: one queued expectation per cycle, compared on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("imem_addr",   imem_addr,   e.addr);
      chk("id_valid",    {31'd0, id_valid}, {31'd0, e.valid});
      chk("id_instr",    id_instr,    e.instr);
      chk("id_pc",       id_pc,       e.pc);
      chk("id_pc_plus4", id_pc_plus4, e.pc4);
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetch_cnt",  perf_fetch_cnt,  e.fcnt);
      chk("perf_bubble_cnt", perf_bubble_cnt, e.bcnt);
`endif
      $display("txn t=%0t addr=%08h valid=%0b instr=%08h pc=%08h pc4=%08h",
               $time, imem_addr, id_valid, id_instr, id_pc, id_pc_plus4);
    end
  end

  logic [31:0] fcnt_m = 0;
  logic [31:0] bcnt_m = 0;

  task automatic step(input logic r, input logic s, input logic rv, input logic [31:0] rpc,
                      input logic [31:0] e_addr, input logic e_valid, input logic [31:0] e_instr,
                      input logic [31:0] e_pc, input logic [31:0] e_pc4);
    exp_t e;
    rst = r; stall = s; redirect_valid = rv; redirect_pc = rpc;
    if (r) begin
      fcnt_m = 0; bcnt_m = 0;
    end else if (rv) begin
      bcnt_m = bcnt_m + 1;
    end else if (!s) begin
      fcnt_m = fcnt_m + 1;
    end
    @(posedge clk);
    e.addr = e_addr; e.valid = e_valid; e.instr = e_instr; e.pc = e_pc; e.pc4 = e_pc4;
    e.fcnt = fcnt_m; e.bcnt = bcnt_m;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    @(negedge clk);
    //    rst   stall rv    rpc            addr           v     instr          pc             pc4
    step(1'b1, 1'b0, 1'b0, 32'h0,        32'h0000_0000, 1'b0, 32'h0000_0013, 32'h0,         32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0,        32'h0000_0004, 1'b1, 32'hC0DE_0000, 32'h0,         32'h4);
    step(1'b0, 1'b0, 1'b0, 32'h0,        32'h0000_0008, 1'b1, 32'hC0DE_0004, 32'h4,         32'h8);
    // stall three cycles at pc=0x8
    step(1'b0, 1'b1, 1'b0, 32'h0,        32'h0000_0008, 1'b1, 32'hC0DE_0004, 32'h4,         32'h8);
    step(1'b0, 1'b1, 1'b0, 32'h0,        32'h0000_0008, 1'b1, 32'hC0DE_0004, 32'h4,         32'h8);
    step(1'b0, 1'b1, 1'b0, 32'h0,        32'h0000_0008, 1'b1, 32'hC0DE_0004, 32'h4,         32'h8);
    step(1'b0, 1'b0, 1'b0, 32'h0,        32'h0000_000C, 1'b1, 32'hC0DE_0008, 32'h8,         32'hC);
    step(1'b0, 1'b0, 1'b0, 32'h0,        32'h0000_0010, 1'b1, 32'hC0DE_000C, 32'hC,         32'h10);
    // redirect to 0x40 from pc=0x10
    step(1'b0, 1'b0, 1'b1, 32'h40,       32'h0000_0040, 1'b0, 32'h0000_0013, 32'hC,         32'h10);
    step(1'b0, 1'b0, 1'b0, 32'h0,        32'h0000_0044, 1'b1, 32'hC0DE_0040, 32'h40,        32'h44);
    // redirect with stall, misaligned target
    step(1'b0, 1'b1, 1'b1, 32'h103,      32'h0000_0100, 1'b0, 32'h0000_0013, 32'h40,        32'h44);
    step(1'b0, 1'b0, 1'b0, 32'h0,        32'h0000_0104, 1'b1, 32'hC0DE_0100, 32'h100,       32'h104);
    // back-to-back redirects, the second lands on the top word
    step(1'b0, 1'b0, 1'b1, 32'h200,      32'h0000_0200, 1'b0, 32'h0000_0013, 32'h100,       32'h104);
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF,32'hFFFF_FFFC, 1'b0, 32'h0000_0013, 32'h100,       32'h104);
    // wrap
    step(1'b0, 1'b0, 1'b0, 32'h0,        32'h0000_0000, 1'b1, 32'hC0DE_FFFC, 32'hFFFF_FFFC, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0,        32'h0000_0004, 1'b1, 32'hC0DE_0000, 32'h0,         32'h4);
    step(1'b0, 1'b0, 1'b0, 32'h0,        32'h0000_0008, 1'b1, 32'hC0DE_0004, 32'h4,         32'h8);
    step(1'b0, 1'b0, 1'b0, 32'h0,        32'h0000_000C, 1'b1, 32'hC0DE_0008, 32'h8,         32'hC);
    step(1'b0, 1'b0, 1'b0, 32'h0,        32'h0000_0010, 1'b1, 32'hC0DE_000C, 32'hC,         32'h10);
    step(1'b0, 1'b0, 1'b0, 32'h0,        32'h0000_0014, 1'b1, 32'hC0DE_0010, 32'h10,        32'h14);
    step(1'b0, 1'b0, 1'b0, 32'h0,        32'h0000_0018, 1'b1, 32'hC0DE_0014, 32'h14,        32'h18);
    step(1'b0, 1'b0, 1'b0, 32'h0,        32'h0000_001C, 1'b1, 32'hC0DE_0018, 32'h18,        32'h1C);
    step(1'b0, 1'b0, 1'b0, 32'h0,        32'h0000_0020, 1'b1, 32'hC0DE_001C, 32'h1C,        32'h20);
    // stall at pc=0x20, then reset during the stall (with a redirect also pending)
    step(1'b0, 1'b1, 1'b0, 32'h0,        32'h0000_0020, 1'b1, 32'hC0DE_001C, 32'h1C,        32'h20);
    step(1'b1, 1'b1, 1'b1, 32'h80,       32'h0000_0000, 1'b0, 32'h0000_0013, 32'h0,         32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0,        32'h0000_0004, 1'b1, 32'hC0DE_0000, 32'h0,         32'h4);
    rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
